// File: rtl/li_expander.sv
// ---------------------------------------------------------------------------
// li_expander
//   Expands a 32-bit constant load into the shortest MIPS sequence that
//   rebuilds it in register rt: addiu, ori, lui, or lui followed by ori.
//   Words are streamed one per handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. Once out_valid is raised it stays high,
// with out_instr/out_last stable, until that transfer happens. in_ready
// depends on state only; a producer must hold its request until accepted.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        request present
//   in_ready        expander idle and able to accept a request
//   in_value[31:0]  constant to load
//   in_rt[4:0]      destination register
//   out_valid       out_instr holds a valid instruction word
//   out_ready       consumer accepts out_instr
//   out_instr[31:0] encoded instruction word
//   out_last        final word of the current sequence
//   expand_cnt      number of two-word expansions, wraps at 16 bits
// ---------------------------------------------------------------------------
module li_expander (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic [15:0] expand_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT1 = 2'd1,
    ST_EMIT2 = 2'd2
  } state_e;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  state_e      state_q, state_d;
  logic [15:0] lo_q, lo_d;
  logic [4:0]  rt_q, rt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;
  logic [15:0] cnt_q, cnt_d;

  // Request classification, evaluated directly on the request inputs.
  logic [15:0] req_lo;
  logic [15:0] req_hi;
  logic        is_sext;
  logic        is_zext;
  logic        is_hionly;
  logic        is_full;
  logic [31:0] first_word;
  logic [31:0] ori_word;

  always_comb begin
    req_lo     = in_value[15:0];
    req_hi     = in_value[31:16];
    is_sext    = (in_value[31:15] == '0) || (in_value[31:15] == '1);
    is_zext    = (req_hi == 16'h0000);
    is_hionly  = (req_lo == 16'h0000);
    is_full    = !is_sext && !is_zext && !is_hionly;
    if (is_sext) begin
      first_word = {OP_ADDIU, 5'd0, in_rt, req_lo};
    end else if (is_zext) begin
      first_word = {OP_ORI, 5'd0, in_rt, req_lo};
    end else begin
      // HIONLY and FULL both start with lui rt,hi.
      first_word = {OP_LUI, 5'd0, in_rt, req_hi};
    end
  end

  // Second word of a FULL expansion, built from the latched request.
  assign ori_word = {OP_ORI, rt_q, rt_q, lo_q};

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    rt_d        = rt_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          lo_d        = in_value[15:0];
          rt_d        = in_rt;
          out_valid_d = 1'b1;
          out_instr_d = first_word;
          out_last_d  = !is_full;
          state_d     = ST_EMIT1;
        end
      end
      ST_EMIT1: begin
        if (out_ready) begin
          // out_last_q already records whether this was a one-word sequence.
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            out_instr_d = ori_word;
            out_last_d  = 1'b1;
            cnt_d       = cnt_q + 16'd1;
            state_d     = ST_EMIT2;
          end
        end
      end
      ST_EMIT2: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lo_q        <= 16'h0000;
      rt_q        <= 5'd0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      out_last_q  <= 1'b0;
      cnt_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      rt_q        <= rt_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_last   = out_last_q;
  assign expand_cnt = cnt_q;

endmodule

// File: doc/li_expander.md
# li_expander

Sequential pseudo-instruction expander for the MIPS mono-cycle toolchain path. It is the inverse of `sign_extend`: given a 32-bit constant and a destination register, it emits the shortest MIPS instruction sequence that rebuilds the constant. The sequence uses `addiu`, `ori`, `lui` or `lui`+`ori`. It sits between the test-program loader and instruction memory, and streams words over a valid/ready handshake.

## Interface
- No parameters. Widths are fixed by the MIPS ISA.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a constant request is present.
- `in_ready`  out  1  expander can accept a request.
- `in_value`  in  32  constant to load.
- `in_rt`  in  5  destination register number.
- `out_valid`  out  1  `out_instr` holds a valid instruction word.
- `out_ready`  in  1  consumer accepts `out_instr`.
- `out_instr`  out  32  encoded instruction word.
- `out_last`  out  1  marks the final word of the current sequence.
- `expand_cnt`  out  16  count of two-word expansions; wraps 0xFFFF→0x0000.

## Operation
- Request fields:
  - lo = `in_value[15:0]`, hi = `in_value[31:16]`.
  - Latch value and rt when a request is accepted.
- Classification, first match wins:
  - **SEXT**: `in_value[31:15]` all 0 or all 1 → one word, `addiu rt,$zero,lo` = 0x24000000 | rt<<16 | lo.
  - **ZEXT**: hi == 0 (value ≥ 0x8000) → one word, `ori rt,$zero,lo` = 0x34000000 | rt<<16 | lo.
  - **HIONLY**: lo == 0 → one word, `lui rt,hi` = 0x3C000000 | rt<<16 | hi.
  - **FULL**: anything else → two words, in this order:
    - `lui rt,hi`
    - `ori rt,rt,lo` = 0x34000000 | rt<<21 | rt<<16 | lo.
- rt = 0 is encoded normally, with no special case.
- FSM states:
  - **IDLE**:
    - `in_ready`=1, `out_valid`=0.
    - On `in_valid`: latch the request, classify it, go to EMIT1.
  - **EMIT1**:
    - `out_valid`=1, `out_instr` = first word.
    - `out_last`=1 unless FULL.
    - On `out_ready`: go to IDLE if single-word, otherwise go to EMIT2.
    - `expand_cnt` increments when the EMIT1→EMIT2 transition is taken.
  - **EMIT2**:
    - `out_valid`=1, `out_instr` = ori word, `out_last`=1.
    - On `out_ready`: go to IDLE.
- Handshake rules:
  - `in_ready` is high only in IDLE. Requests presented in other states are not accepted and must be held by the producer.
  - While `out_valid`=1 and `out_ready`=0, `out_instr` and `out_last` stay stable.
  - `out_valid` is never withdrawn without a completed handshake.
- Reset values:
  - state IDLE, `in_ready`=1, `out_valid`=0, `out_instr`=0, `out_last`=0, `expand_cnt`=0.
- Reset mid-operation:
  - Asserting `rst_n`=0 in EMIT1 or EMIT2 aborts the sequence immediately (asynchronous).
  - Every output goes to its reset value.
  - No partial sequence resumes after reset is released.

## Timing
- Request accepted at edge N → `out_valid`=1 from edge N (registered outputs, visible in cycle N+1).
- Single-word case:
  - Handshake at edge M → `in_ready`=1 in the cycle after M.
  - Minimum 2 cycles per request.
- FULL case:
  - Second word appears the cycle after the first handshake.
  - Minimum 3 cycles per request.
- No combinational path from `out_ready` to `out_instr`, or from `in_valid` to `out_*`.
- `in_ready` depends only on state: combinational from state is allowed, but not from inputs.
- `expand_cnt` updates on the same edge as the EMIT1→EMIT2 transition.

## Test plan
- **SEXT**: value 0x00000005, rt=8 → one word 0x24080005, `out_last`=1. Also value 0xFFFF8000, rt=9 → 0x24098000.
- **ZEXT and HIONLY**: value 0x00008000, rt=10 → 0x340A8000. Value 0x12340000, rt=11 → 0x3C0B1234. Both single-word, `expand_cnt` unchanged.
- **FULL with backpressure**: value 0x12345678, rt=12, `out_ready` held 0 for 3 cycles.
  - 0x3C0C1234 is held stable with `out_last`=0.
  - Then 0x358C5678 with `out_last`=1.
  - `expand_cnt` 0→1.
  - `in_ready` stays 0 throughout the sequence.
- **Back-to-back**: 0x00000000 then 0xFFFFFFFF (rt=1), `out_ready`=1 throughout → 0x24010000, then 0x2401FFFF. Check the IDLE gap cycle between them.
- **Reset mid-FULL**: assert `rst_n`=0 while in EMIT2 → `out_valid`=0 and `expand_cnt`=0 immediately, `in_ready`=1 after release. A new request for 0x00000007, rt=2 yields 0x24020007.
- **Counter wrap**: 65536 FULL requests (e.g. 0x00010001) → `expand_cnt` returns to 0x0000.
